// File: rtl/irq_pio_gen2_pkg.sv
// irq_pio_gen2_pkg: register map and reset constants for the interrupt input PIO
package irq_pio_gen2_pkg;
  localparam logic [2:0] ADDR_DATA       = 3'd0;
  localparam logic [2:0] ADDR_RISE_EN    = 3'd1;
  localparam logic [2:0] ADDR_IRQ_MASK   = 3'd2;
  localparam logic [2:0] ADDR_EDGE_CAP   = 3'd3;
  localparam logic [2:0] ADDR_FALL_EN    = 3'd4;
  localparam logic [2:0] ADDR_IRQ_STATUS = 3'd5;
  localparam logic [31:0] FALL_EN_RST    = 32'hFFFF_FFFF;
endpackage

// File: rtl/irq_pio_gen2_debounce_bit.sv
// irq_pio_gen2_debounce_bit: synchroniser, optional debounce filter and edge-history flops for one pin
module irq_pio_gen2_debounce_bit #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin_i,
  output logic filt_o,
  output logic cur_o,
  output logic prev_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic cur_q, prev_q;
  // shift the asynchronous pin through the synchroniser chain
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
  if (DEBOUNCE_CYCLES == 0) begin : g_bypass
    assign filt_o = sync_q[SYNC_STAGES-1];
  end else begin : g_filter
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic filt_q;
    // accept a new level only after it has differed from the filtered value for DEBOUNCE_CYCLES clocks
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        cnt_q  <= '0;
        filt_q <= 1'b0;
      end else if (sync_q[SYNC_STAGES-1] == filt_q) cnt_q <= '0;
      else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        filt_q <= sync_q[SYNC_STAGES-1];
        cnt_q  <= '0;
      end else cnt_q <= cnt_q + 1'b1;
    assign filt_o = filt_q;
  end
  // edge history: cur/prev pair feeds the rise/fall comparison in the parent
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cur_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      cur_q  <= filt_o;
      prev_q <= cur_q;
    end
  assign cur_o  = cur_q;
  assign prev_o = prev_q;
endmodule

// File: rtl/irq_pio_gen2.sv
// irq_pio_gen2: Avalon-MM interrupt input PIO with per-bit edge/level capture, mask and W1C clear
module irq_pio_gen2 #(
  parameter int WIDTH           = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq,
  output logic [31:0]      readdata
);
  import irq_pio_gen2_pkg::*;
  logic [WIDTH-1:0] filt, cur, prev, set, w1c, cap_d;
  logic [WIDTH-1:0] rise_en_q, fall_en_q, mask_q, cap_q;
  logic [31:0] rd_d;
  logic wr, unused_wdata;
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    irq_pio_gen2_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk    (clk),
      .reset_n(reset_n),
      .pin_i  (in_port[i]),
      .filt_o (filt[i]),
      .cur_o  (cur[i]),
      .prev_o (prev[i])
    );
  end
  assign unused_wdata = ^writedata;
  // capture set/clear: a same-cycle set beats the W1C so no event is lost
  always_comb begin
    wr    = chipselect & ~write_n;
    w1c   = (wr && address == ADDR_EDGE_CAP) ? writedata[WIDTH-1:0] : '0;
    set   = (cur & ~prev & rise_en_q) | (~cur & prev & fall_en_q) | (cur & ~rise_en_q & ~fall_en_q);
    cap_d = (cap_q & ~w1c) | set;
    rd_d  = address == ADDR_DATA       ? 32'(filt) :
            address == ADDR_RISE_EN    ? 32'(rise_en_q) :
            address == ADDR_IRQ_MASK   ? 32'(mask_q) :
            address == ADDR_EDGE_CAP   ? 32'(cap_q) :
            address == ADDR_FALL_EN    ? 32'(fall_en_q) :
            address == ADDR_IRQ_STATUS ? 32'(cap_q & mask_q) : '0;
  end
  // control registers, capture register and registered read data
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      rise_en_q <= '0;
      fall_en_q <= FALL_EN_RST[WIDTH-1:0];
      mask_q    <= '0;
      cap_q     <= '0;
      readdata  <= '0;
    end else begin
      if (wr && address == ADDR_RISE_EN) rise_en_q <= writedata[WIDTH-1:0];
      if (wr && address == ADDR_FALL_EN) fall_en_q <= writedata[WIDTH-1:0];
      if (wr && address == ADDR_IRQ_MASK) mask_q <= writedata[WIDTH-1:0];
      cap_q    <= cap_d;
      readdata <= rd_d;
    end
  assign irq = |(cap_q & mask_q);
endmodule

// File: tb/tb_irq_pio_gen2.sv
// tb_irq_pio_gen2: directed stimulus with a queued scoreboard checked by a negedge monitor
module tb_irq_pio_gen2;
  logic clk = 1'b0, reset_n = 1'b0;
  logic [2:0] address = '0;
  logic chipselect = 1'b0, write_n = 1'b1;
  logic [31:0] writedata = '0;
  logic [7:0] in_port = 8'hFF, in_port_db = 8'h00;
  logic irq, irq_db;
  logic [31:0] readdata, readdata_db;
  typedef struct {string name; int sel; logic [31:0] exp;} exp_t;
  exp_t q[$];
  exp_t e;
  logic chk_v = 1'b0;
  logic [31:0] act;
  int n_chk = 0, n_pass = 0;

  irq_pio_gen2 #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port), .irq(irq), .readdata(readdata));
  irq_pio_gen2 #(.WIDTH(8), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut_db (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port_db), .irq(irq_db), .readdata(readdata_db));

  always #5 clk = ~clk;

  // monitor: pop the expected value whenever a check is presented and compare
  always @(negedge clk)
    if (chk_v) begin
      n_chk++;
      if (q.size() == 0) $display("FAIL scoreboard_empty: no expected value queued");
      else begin
        e = q.pop_front();
        act = e.sel == 0 ? readdata : e.sel == 1 ? {31'b0, irq} : e.sel == 2 ? readdata_db : {31'b0, irq_db};
        if (act === e.exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
      end
    end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask
  task automatic expect_sig(input string name, input int sel, input logic [31:0] exp);
    q.push_back('{name, sel, exp});
    chk_v = 1'b1;
    tick();
    chk_v = 1'b0;
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
  endtask
  task automatic rd(input string name, input logic [2:0] a, input logic [31:0] exp, input bit db);
    address = a;
    tick();
    expect_sig(name, db ? 2 : 0, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    ticks(2);
    expect_sig("reset_readdata", 0, 32'h0);
    expect_sig("reset_irq", 1, 32'h0);
    reset_n = 1'b1;
    ticks(6);
    rd("data_after_reset", 3'd0, 32'hFF, 0);
    rd("cap_after_reset", 3'd3, 32'h00, 0);
    rd("fall_en_reset", 3'd4, 32'hFF, 0);
    rd("rise_en_reset", 3'd1, 32'h00, 0);
    expect_sig("irq_after_reset", 1, 32'h0);
    wr(3'd0, 32'h0);
    rd("data_ro_write", 3'd0, 32'hFF, 0);
    wr(3'd6, 32'hFF);
    rd("addr6_zero", 3'd6, 32'h0, 0);
    wr(3'd2, 32'h01);
    rd("mask_rw", 3'd2, 32'h01, 0);
    // falling edge on bit 0: irq after edge 3
    in_port = 8'hFE;
    ticks(3);
    expect_sig("fall_irq_edge2", 1, 32'h0);
    expect_sig("fall_irq_edge3", 1, 32'h1);
    rd("fall_cap", 3'd3, 32'h01, 0);
    rd("fall_status", 3'd5, 32'h01, 0);
    wr(3'd3, 32'h01);
    expect_sig("w1c_irq_clear", 1, 32'h0);
    rd("w1c_cap_clear", 3'd3, 32'h00, 0);
    // W1C selectivity
    in_port = 8'hFF;
    ticks(6);
    in_port = 8'hFA;
    ticks(6);
    rd("sel_cap_05", 3'd3, 32'h05, 0);
    wr(3'd3, 32'h04);
    rd("sel_cap_01", 3'd3, 32'h01, 0);
    expect_sig("sel_irq_stays", 1, 32'h1);
    wr(3'd3, 32'h01);
    // rise on bit 1 coinciding with its W1C
    wr(3'd1, 32'h02);
    wr(3'd4, 32'hFD);
    in_port = 8'hF8;
    ticks(6);
    rd("rise_only_no_fall", 3'd3, 32'h00, 0);
    in_port = 8'hFA;
    ticks(3);
    wr(3'd3, 32'h02);
    rd("set_beats_w1c", 3'd3, 32'h02, 0);
    wr(3'd3, 32'h02);
    rd("rise_cleared", 3'd3, 32'h00, 0);
    // level mode on bit 2
    wr(3'd4, 32'hF9);
    in_port = 8'hFE;
    ticks(6);
    rd("level_set", 3'd3, 32'h04, 0);
    wr(3'd3, 32'h04);
    rd("level_w1c_resets", 3'd3, 32'h04, 0);
    in_port = 8'hFA;
    ticks(6);
    rd("level_sticky_low", 3'd3, 32'h04, 0);
    wr(3'd3, 32'h04);
    rd("level_cleared", 3'd3, 32'h00, 0);
    // debounce instance: glitch rejected, 4-cycle pulse captured after edge 7
    wr(3'd1, 32'h01);
    in_port_db = 8'h01;
    ticks(3);
    in_port_db = 8'h00;
    ticks(10);
    rd("db_glitch_data", 3'd0, 32'h00, 1);
    expect_sig("db_glitch_irq", 3, 32'h0);
    in_port_db = 8'h01;
    ticks(4);
    in_port_db = 8'h00;
    ticks(3);
    expect_sig("db_pulse_edge6", 3, 32'h0);
    expect_sig("db_pulse_edge7", 3, 32'h1);
    // asynchronous reset mid-operation
    reset_n = 1'b0;
    expect_sig("async_rst_irq", 3, 32'h0);
    expect_sig("async_rst_rdata", 2, 32'h0);
    reset_n = 1'b1;
    ticks(2);
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL scoreboard_drain: %0d left, required 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
